// File: rtl/count_gate_ctrl.sv
// ---------------------------------------------------------------------------
// count_gate_ctrl
//
// Measurement-window controller for a pulse-edge counter. On an accepted
// start it clears the counter, opens the counter enable gate for exactly
// N clocks, waits a settle interval so the last counted edge has
// propagated, captures the counter value and offers it on a valid/ready
// result interface.
//
// Optional feature macro: GATE_AUTO_REARM_EN
//   defined   : after the result handshake the controller re-clears the
//               counter and opens a new gate with the same latched N
//               (continuous measurement); abort in HOLD returns to IDLE.
//   undefined : the handshake returns to IDLE; abort in HOLD is ignored.
//
// Parameters
//   CW            width of counter value and result
//   GW            width of gate length and gate timer
//   SETTLE_CYCLES clocks between gate close and capture (1..15)
//
// Ports
//   i_clk           system clock
//   i_rst           asynchronous, active-high reset
//   i_start         one-cycle request to begin a measurement
//   i_abort         synchronous cancel of a measurement in progress
//   i_gate_cycles   gate length N, sampled when start is accepted
//   i_count_in      current counter value
//   o_count_clr     one-cycle clear strobe to the counter
//   o_en_count      counter enable gate
//   o_result        captured count
//   o_result_valid  result available
//   i_result_ready  consumer accepts result
//   o_busy          high whenever the controller is not idle
//   o_cfg_err       one-cycle pulse when a start with N == 0 is rejected
// ---------------------------------------------------------------------------
module count_gate_ctrl #(
    parameter int CW            = 16,
    parameter int GW            = 24,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic [GW-1:0] i_gate_cycles,
    input  logic [CW-1:0] i_count_in,
    output logic          o_count_clr,
    output logic          o_en_count,
    output logic [CW-1:0] o_result,
    output logic          o_result_valid,
    input  logic          i_result_ready,
    output logic          o_busy,
    output logic          o_cfg_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_GATE   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    // Out-of-range settle values are clamped so the settle timer always
    // reaches its terminal count of one.
    localparam int SETTLE_CLAMP = (SETTLE_CYCLES < 1)  ? 1  :
                                  (SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES;
    localparam logic [3:0] SETTLE_LOAD = SETTLE_CLAMP[3:0];

    logic [2:0]    r_state;
    logic [2:0]    w_next_state;
    logic [GW-1:0] r_gate_n;
    logic [GW-1:0] r_gate_timer;
    logic [3:0]    r_settle_timer;
    logic [CW-1:0] r_result;
    logic          r_result_valid;
    logic          r_count_clr;
    logic          r_en_count;
    logic          r_busy;
    logic          r_cfg_err;

    logic          w_start_ok;
    logic          w_start_bad;
    logic          w_handshake;

    assign w_start_ok  = i_start && (i_gate_cycles != '0);
    assign w_start_bad = i_start && (i_gate_cycles == '0);
    assign w_handshake = r_result_valid && i_result_ready;

    // Next-state decode. The gate and settle timers count down to one
    // rather than zero: a timer loaded with N then spends exactly N cycles
    // in its state, and the full-scale N = 2^GW-1 never needs a wrap.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_next_state = i_abort ? S_IDLE : S_GATE;
            end
            S_GATE: begin
                if (i_abort) begin
                    w_next_state = S_IDLE;
                end else if (r_gate_timer == GW'(1)) begin
                    w_next_state = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (i_abort) begin
                    w_next_state = S_IDLE;
                end else if (r_settle_timer == 4'd1) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
`ifdef GATE_AUTO_REARM_EN
                if (i_abort) begin
                    w_next_state = S_IDLE;
                end else if (w_handshake) begin
                    w_next_state = S_CLEAR;
                end
`else
                if (w_handshake) begin
                    w_next_state = S_IDLE;
                end
`endif
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register, latched gate length and the two countdown timers.
    // N is only latched in IDLE so an auto-rearm cycle reuses it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_gate_n       <= '0;
            r_gate_timer   <= '0;
            r_settle_timer <= '0;
        end else begin
            r_state <= w_next_state;

            if (r_state == S_IDLE && w_start_ok) begin
                r_gate_n <= i_gate_cycles;
            end

            if (r_state == S_CLEAR) begin
                r_gate_timer <= r_gate_n;
            end else if (r_state == S_GATE && r_gate_timer != '0) begin
                r_gate_timer <= r_gate_timer - GW'(1);
            end

            if (r_state == S_GATE && w_next_state == S_SETTLE) begin
                r_settle_timer <= SETTLE_LOAD;
            end else if (r_state == S_SETTLE && r_settle_timer != 4'd0) begin
                r_settle_timer <= r_settle_timer - 4'd1;
            end
        end
    end

    // Output registers are decoded from the next state so each strobe lines
    // up with the cycle the controller actually spends in that state, while
    // keeping every output behind a flop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count_clr    <= 1'b0;
            r_en_count     <= 1'b0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_cfg_err      <= 1'b0;
        end else begin
            r_count_clr    <= (w_next_state == S_CLEAR);
            r_en_count     <= (w_next_state == S_GATE);
            r_result_valid <= (w_next_state == S_HOLD);
            r_busy         <= (w_next_state != S_IDLE);
            r_cfg_err      <= (r_state == S_IDLE) && w_start_bad;
        end
    end

    // The counter is sampled exactly once, on the SETTLE -> HOLD step; an
    // abort or handshake leaves the last captured value in place.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_result <= '0;
        end else if (r_state == S_SETTLE && w_next_state == S_HOLD) begin
            r_result <= i_count_in;
        end
    end

    assign o_count_clr    = r_count_clr;
    assign o_en_count     = r_en_count;
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_busy         = r_busy;
    assign o_cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_count_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_count_gate_ctrl
//
// Drives count_gate_ctrl together with a small pulse-edge counter model.
// The pulse toggles every 20 ns against a 10 ns clock, so an open gate of
// N cycles sees N/4 rising edges. Expected results are queued when a
// measurement is started and popped when the result handshake happens.
// ---------------------------------------------------------------------------
module tb_count_gate_ctrl;

   localparam int CW       = 16;
   localparam int GW       = 24;
   localparam int SETTLE   = 4;
   localparam int N_FULL   = 1000;
   localparam int EXP_FULL = N_FULL / 4;

   logic          clk;
   logic          rst;
   logic          start;
   logic          abort;
   logic [GW-1:0] gateCycles;
   logic [CW-1:0] countIn;
   logic          countClr;
   logic          enCount;
   logic [CW-1:0] result;
   logic          resultValid;
   logic          resultReady;
   logic          busy;
   logic          cfgErr;
   logic          pulse;
   logic          pulseD;

   int            checks = 0;
   int            errors = 0;
   logic [31:0]   sbQueue[$];

   count_gate_ctrl #(
      .CW(CW),
      .GW(GW),
      .SETTLE_CYCLES(SETTLE)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_start(start),
      .i_abort(abort),
      .i_gate_cycles(gateCycles),
      .i_count_in(countIn),
      .o_count_clr(countClr),
      .o_en_count(enCount),
      .o_result(result),
      .o_result_valid(resultValid),
      .i_result_ready(resultReady),
      .o_busy(busy),
      .o_cfg_err(cfgErr)
   );

   // 10 ns clock with rising edges at 5, 15, 25 ns ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Pulse source rising at 20, 60, 100 ns ..., never on a clock edge.
   initial begin
      pulse = 1'b0;
      forever #20 pulse = ~pulse;
   end

   // Pulse-edge counter standing in for the upstream counter block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         countIn <= '0;
         pulseD  <= 1'b0;
      end else begin
         pulseD <= pulse;
         if (countClr) begin
            countIn <= '0;
         end else if (enCount && pulse && !pulseD) begin
            countIn <= countIn + 16'd1;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic a,
                                input logic [GW-1:0] g, input logic r);
      start       = s;
      abort       = a;
      gateCycles  = g;
      resultReady = r;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Runs until a result has been seen and the controller is idle again.
   task automatic runToIdle(input int budget, output int enCnt,
                            output int validCnt, output bit done);
      enCnt    = 0;
      validCnt = 0;
      done     = 1'b0;
      for (int k = 0; k < budget && !done; k++) begin
         tick();
         if (enCount) enCnt++;
         if (resultValid) validCnt++;
         if (validCnt > 0 && !busy) done = 1'b1;
      end
   endtask

   // Scoreboard: every completed handshake pops one expected result.
   always @(negedge clk) begin
      if (!rst && resultValid && resultReady) begin
         if (sbQueue.size() == 0) begin
            checkOutput("sb_unexpected_result", 32'd1, 32'd0);
         end else begin
            checkOutput("sb_result", 32'(result), sbQueue.pop_front());
         end
      end
   end

   initial begin
      #500_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int enCnt;
      int validCnt;
      int busyLow;
      bit done;

      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      #12;
      checkOutput("rst_count_clr", 32'(countClr), 32'd0);
      checkOutput("rst_en_count", 32'(enCount), 32'd0);
      checkOutput("rst_result", 32'(result), 32'd0);
      checkOutput("rst_result_valid", 32'(resultValid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_cfg_err", 32'(cfgErr), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();

`ifndef GATE_AUTO_REARM_EN
      // Single full measurement with the consumer always ready.
      $display("[TB] single measurement N=%0d", N_FULL);
      sbQueue.push_back(32'(EXP_FULL));
      applyStimulus(1'b1, 1'b0, GW'(N_FULL), 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, GW'(N_FULL), 1'b1);
      runToIdle(N_FULL + 100, enCnt, validCnt, done);
      checkOutput("single_done", 32'(done), 32'd1);
      checkOutput("single_en_cycles", 32'(enCnt), 32'(N_FULL));
      checkOutput("single_valid_cycles", 32'(validCnt), 32'd1);
      checkOutput("single_busy_after", 32'(busy), 32'd0);

      // Latency with N=5, start aligned to the pulse so one edge falls
      // inside the gate.
      $display("[TB] latency N=5");
      @(posedge pulse);
      @(posedge clk);
      #1;
      sbQueue.push_back(32'd1);
      applyStimulus(1'b1, 1'b0, GW'(5), 1'b1);
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 1) applyStimulus(1'b0, 1'b0, GW'(5), 1'b1);
         checkOutput("lat_count_clr", 32'(countClr), 32'(k == 1));
         checkOutput("lat_en_count", 32'(enCount), 32'(k >= 2 && k <= 6));
         checkOutput("lat_result_valid", 32'(resultValid), 32'(k == 2 + 5 + SETTLE));
         checkOutput("lat_busy", 32'(busy), 32'(k <= 11));
      end

      // Backpressure: result must hold while ready is low, starts ignored.
      $display("[TB] backpressure");
      sbQueue.push_back(32'(EXP_FULL));
      applyStimulus(1'b1, 1'b0, GW'(N_FULL), 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, GW'(N_FULL), 1'b0);
      done = 1'b0;
      for (int k = 0; k < N_FULL + 100 && !done; k++) begin
         tick();
         if (resultValid) done = 1'b1;
      end
      checkOutput("bp_reached_hold", 32'(done), 32'd1);
      for (int k = 0; k < 50; k++) begin
         applyStimulus(k == 10 || k == 20, 1'b0, (k == 20) ? GW'(0) : GW'(7), 1'b0);
         tick();
         checkOutput("bp_valid_held", 32'(resultValid), 32'd1);
         checkOutput("bp_result_held", 32'(result), 32'(EXP_FULL));
         checkOutput("bp_no_cfg_err", 32'(cfgErr), 32'd0);
         checkOutput("bp_no_clear", 32'(countClr), 32'd0);
      end
      applyStimulus(1'b0, 1'b0, GW'(N_FULL), 1'b1);
      tick();
      checkOutput("bp_valid_drop", 32'(resultValid), 32'd0);
      checkOutput("bp_idle_after", 32'(busy), 32'd0);
      checkOutput("bp_result_kept", 32'(result), 32'(EXP_FULL));

      // Rejected start with a zero gate length.
      $display("[TB] config error");
      applyStimulus(1'b1, 1'b0, '0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, '0, 1'b1);
      checkOutput("cfg_err_pulse", 32'(cfgErr), 32'd1);
      checkOutput("cfg_busy", 32'(busy), 32'd0);
      checkOutput("cfg_no_clear", 32'(countClr), 32'd0);
      tick();
      checkOutput("cfg_err_one_cycle", 32'(cfgErr), 32'd0);
      checkOutput("cfg_no_en", 32'(enCount), 32'd0);
      checkOutput("cfg_busy_after", 32'(busy), 32'd0);

      // Abort at gate cycle 300 of 1000.
      $display("[TB] abort mid-gate");
      applyStimulus(1'b1, 1'b0, GW'(N_FULL), 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, GW'(N_FULL), 1'b1);
      repeat (300) tick();
      checkOutput("abort_in_gate", 32'(enCount), 32'd1);
      applyStimulus(1'b0, 1'b1, GW'(N_FULL), 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, GW'(N_FULL), 1'b1);
      checkOutput("abort_en_low", 32'(enCount), 32'd0);
      checkOutput("abort_clr_low", 32'(countClr), 32'd0);
      checkOutput("abort_busy_low", 32'(busy), 32'd0);
      validCnt = 0;
      for (int k = 0; k < N_FULL + 100; k++) begin
         tick();
         if (resultValid) validCnt++;
      end
      checkOutput("abort_no_result", 32'(validCnt), 32'd0);
      checkOutput("abort_result_kept", 32'(result), 32'(EXP_FULL));

      // New start after abort, issued together with abort (start wins).
      $display("[TB] restart after abort");
      sbQueue.push_back(32'(EXP_FULL));
      applyStimulus(1'b1, 1'b1, GW'(N_FULL), 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, GW'(N_FULL), 1'b1);
      checkOutput("restart_clr", 32'(countClr), 32'd1);
      checkOutput("restart_busy", 32'(busy), 32'd1);
      runToIdle(N_FULL + 100, enCnt, validCnt, done);
      checkOutput("restart_done", 32'(done), 32'd1);
      checkOutput("restart_en_cycles", 32'(enCnt), 32'(N_FULL));
`else
      // Continuous measurement: three results without returning to IDLE.
      $display("[TB] auto rearm");
      repeat (3) sbQueue.push_back(32'(EXP_FULL));
      applyStimulus(1'b1, 1'b0, GW'(N_FULL), 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, GW'(N_FULL), 1'b1);
      validCnt = 0;
      busyLow  = 0;
      for (int k = 0; k < 4 * N_FULL && validCnt < 3; k++) begin
         tick();
         if (!busy) busyLow++;
         if (resultValid) validCnt++;
      end
      checkOutput("rearm_results", 32'(validCnt), 32'd3);
      checkOutput("rearm_never_idle", 32'(busyLow), 32'd0);
      applyStimulus(1'b0, 1'b1, GW'(N_FULL), 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, GW'(N_FULL), 1'b1);
      checkOutput("rearm_abort_busy", 32'(busy), 32'd0);
      checkOutput("rearm_abort_valid", 32'(resultValid), 32'd0);
`endif

      // Asynchronous reset in the middle of a gate.
      $display("[TB] async reset mid-gate");
      applyStimulus(1'b1, 1'b0, GW'(N_FULL), 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, GW'(N_FULL), 1'b1);
      repeat (100) tick();
      checkOutput("arst_in_gate", 32'(enCount), 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("arst_en_count", 32'(enCount), 32'd0);
      checkOutput("arst_busy", 32'(busy), 32'd0);
      checkOutput("arst_result", 32'(result), 32'd0);
      checkOutput("arst_result_valid", 32'(resultValid), 32'd0);
      checkOutput("arst_count_clr", 32'(countClr), 32'd0);
      #2;
      rst = 1'b0;
      tick();
      tick();
      checkOutput("arst_stays_idle", 32'(busy), 32'd0);

      checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/count_gate_ctrl.md
Name: count_gate_ctrl

Overview:
- Measurement-window controller that sits directly downstream of the pulse-edge counter and drives it.
- Clears the counter and opens an enable gate of exactly N clocks.
- Waits a settle interval, then captures the counter value.
- Presents the captured value on a valid/ready result interface for software or a display stage.

Parameters:
CW, 16, width of count_in and result (matches counter width)
GW, 24, width of gate_cycles and internal gate timer
SETTLE_CYCLES, 4, clocks between gate close and capture (legal range 1..15)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle request to begin a measurement
abort  input  1  synchronous cancel of a measurement in progress
gate_cycles  input  GW  gate length N in clocks, sampled on accepted start
count_in  input  CW  current value from the counter
count_clr  output  1  one-cycle clear strobe to the counter
en_count  output  1  counter enable gate
result  output  CW  captured count
result_valid  output  1  result available
result_ready  input  1  consumer accepts result
busy  output  1  high in any state other than IDLE
cfg_err  output  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (async, active-high): state=IDLE, timers=0, result=0, result_valid=0, count_clr=0, en_count=0, busy=0, cfg_err=0.
- All outputs are registered; no combinational path from any input to any output.
- States and transitions:
  - IDLE: start=1 with gate_cycles!=0 -> latch N, go to CLEAR. start=1 with gate_cycles==0 -> stay IDLE, cfg_err=1 for 1 cycle.
  - CLEAR: count_clr=1 for exactly 1 cycle -> GATE, timer loaded with N.
  - GATE: en_count=1; timer decrements every cycle. After exactly N cycles of en_count high -> SETTLE.
  - SETTLE: en_count=0 for SETTLE_CYCLES cycles -> capture count_in into result, result_valid=1 -> HOLD.
  - HOLD: result_valid held high, result held stable until result_valid&&result_ready; then result_valid=0 the next cycle -> IDLE. result keeps its value after the handshake.
- Timing: start accepted in cycle T -> count_clr high in T+1 -> en_count high T+2..T+1+N -> result_valid high from T+2+N+SETTLE_CYCLES.
- start outside IDLE: ignored, no cfg_err.
- abort in CLEAR/GATE/SETTLE -> IDLE next cycle; en_count and count_clr low next cycle; no result produced; previous result retained.
- abort in HOLD or IDLE: no effect.
- start and abort together in IDLE: start wins.
- N is a full GW-bit unsigned value; N=2^GW-1 must work without timer wrap.
- count_in is sampled once, at capture; overflow/wrap of the counter is the counter's concern.
- rst asserted mid-operation: immediate return to reset values, including result_valid=0.

Optional Feature:
- Macro GATE_AUTO_REARM_EN.
- Defined: after the HOLD handshake, go directly to CLEAR with the same latched N (continuous measurement); busy stays high. abort in HOLD also returns to IDLE, dropping result_valid next cycle.
- Undefined: HOLD handshake returns to IDLE; abort in HOLD has no effect.

Test Plan:
- Bench uses 10 ns clock, counter instantiated, pulse toggling every 20 ns (40 ns period). Single measurement: start with gate_cycles=1000, SETTLE_CYCLES=4, result_ready=1 -> en_count high exactly 1000 cycles, result=250, result_valid one cycle, back to IDLE.
- Latency: start at cycle T, N=5 -> count_clr at T+1, en_count T+2..T+6, result_valid rises at T+11.
- Backpressure: result_ready=0 for 50 cycles -> result_valid and result stable throughout; start pulses during HOLD ignored; ready=1 -> IDLE next cycle.
- Config error: start with gate_cycles=0 -> cfg_err one cycle, count_clr/en_count stay 0, busy stays 0.
- Abort: abort at GATE cycle 300 of 1000 -> en_count low next cycle, no result_valid, prior result unchanged; a new start then works normally.
- Async rst pulsed mid-GATE -> all outputs at reset values immediately. With GATE_AUTO_REARM_EN: 3 back-to-back results of 250 with no IDLE between them.
